// File: rtl/path_replayer.sv
// Replays the solver's path stack bottom-to-top as a valid/ready move stream,
// tracking the rat position and trapping any move that would leave the maze.
module path_replayer #(
    parameter int DEPTH   = 256,
    parameter int PTR_W   = 8,
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [PTR_W:0]     path_len,
    output logic               rd_en,
    output logic [PTR_W-1:0]   rd_addr,
    input  logic [1:0]         rd_data,
    output logic [1:0]         move,
    output logic               move_valid,
    input  logic               move_ready,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_SHOW,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [PTR_W:0]     LP_DEPTH  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]     LP_IDX1   = (PTR_W+1)'(1);
    localparam logic [COORD_W-1:0] LP_MAX    = '1;
    localparam logic [COORD_W-1:0] LP_C1     = COORD_W'(1);

    state_t               r_state;
    state_t               w_next;
    logic [PTR_W:0]       r_idx;
    logic [PTR_W:0]       r_len;
    logic [1:0]           r_move;
    logic [COORD_W-1:0]   r_x;
    logic [COORD_W-1:0]   r_y;
    logic                 w_start;
    logic                 w_accept;
    logic                 w_oob;
    logic                 w_last;
    logic [PTR_W:0]       w_idx_inc;

    assign w_idx_inc = r_idx + LP_IDX1;
    assign w_last    = (w_idx_inc == r_len);
    assign w_accept  = (r_state == S_SHOW) && move_ready;

    // A move is illegal if it would step off the edge of the grid.
    always_comb begin
        w_oob = 1'b0;
        unique case (r_move)
            2'b00: w_oob = (r_y == '0);
            2'b01: w_oob = (r_x == LP_MAX);
            2'b10: w_oob = (r_x == '0);
            2'b11: w_oob = (r_y == LP_MAX);
        endcase
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (run) begin
                    if (path_len > LP_DEPTH) begin
                        w_next = S_ERR;
                    end else if (path_len == '0) begin
                        w_next = S_DONE;
                    end else begin
                        w_next  = S_READ;
                        w_start = 1'b1;
                    end
                end
            end
            S_READ:  w_next = S_LATCH;
            S_LATCH: w_next = S_SHOW;
            S_SHOW: begin
                if (w_accept) begin
                    if (w_oob)       w_next = S_ERR;
                    else if (w_last) w_next = S_DONE;
                    else             w_next = S_READ;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx  <= '0;
            r_len  <= '0;
            r_move <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else begin
            if (w_start) begin
                r_len <= path_len;
                r_idx <= '0;
                r_x   <= '0;
                r_y   <= '0;
            end
            if (r_state == S_LATCH) begin
                r_move <= rd_data;
            end
            if (w_accept && !w_oob) begin
                unique case (r_move)
                    2'b00: r_y <= r_y - LP_C1;
                    2'b01: r_x <= r_x + LP_C1;
                    2'b10: r_x <= r_x - LP_C1;
                    2'b11: r_y <= r_y + LP_C1;
                endcase
                if (!w_last) begin
                    r_idx <= w_idx_inc;
                end
            end
        end
    end

    assign rd_en      = (r_state == S_READ);
    assign rd_addr    = r_idx[PTR_W-1:0];
    assign move       = r_move;
    assign move_valid = (r_state == S_SHOW);
    assign x          = r_x;
    assign y          = r_y;
    assign busy       = (r_state == S_READ) || (r_state == S_LATCH) ||
                        (r_state == S_SHOW);
    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);

endmodule

// File: tb/tb_path_replayer.sv
// Directed bench for path_replayer: vector table of replays plus
// hand-written reset, boundary and full-depth sequences.
`timescale 1ns/1ps
module tb_path_replayer;

    logic       clk;
    logic       rst;
    logic       run;
    logic [8:0] path_len;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [1:0] rd_data;
    logic [1:0] move;
    logic       move_valid;
    logic       move_ready;
    logic [3:0] x;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic       err;

    logic [1:0] mem [0:255];

    int checks;
    int failures;
    int acc;
    int reads;
    int first_v;
    int end_cyc;
    int last_addr;

    path_replayer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .path_len   (path_len),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .move       (move),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .x          (x),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack model: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    typedef struct {
        logic [8:0]  len;
        logic [15:0] moves;
        int          s_idx;
        int          s_n;
        int          s_x;
        int          e_acc;
        int          e_reads;
        int          ex;
        int          ey;
        int          e_done;
        int          e_err;
        int          e_first;
        int          e_end;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic replay(input logic [8:0] len, input int s_idx,
                          input int s_n, input int s_x);
        int stall;
        acc       = 0;
        reads     = 0;
        first_v   = -1;
        end_cyc   = -1;
        last_addr = -1;
        stall     = 0;
        path_len   = len;
        run        = 1'b1;
        move_ready = 1'b1;
        tick();
        run = 1'b0;
        for (int cyc = 1; cyc < 1200; cyc++) begin
            if (done || err) begin
                end_cyc = cyc;
                break;
            end
            if (rd_en) begin
                reads++;
                last_addr = int'(rd_addr);
                chk("rd_addr", int'(rd_addr), acc);
            end
            move_ready = 1'b1;
            if (move_valid) begin
                if (first_v < 0) first_v = cyc;
                chk("move", int'(move), int'(mem[acc]));
                if (acc == s_idx && stall < s_n) begin
                    move_ready = 1'b0;
                    stall++;
                    chk("stall_x", int'(x), s_x);
                end else begin
                    acc++;
                end
            end
            tick();
        end
        if (end_cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL timeout actual=busy required=done_or_err");
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        run        = 1'b0;
        path_len   = '0;
        move_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 2'b00;

        //         len  moves     sidx sn sx acc rd ex ey dn er fst end
        vecs[0] = '{9'd4,   16'h00F5, -1, 0, 0, 4, 4, 2, 2, 1, 0, 3, 13};
        vecs[1] = '{9'd4,   16'h00F5,  1, 5, 1, 4, 4, 2, 2, 1, 0, 3, 18};
        vecs[2] = '{9'd1,   16'h0000, -1, 0, 0, 1, 1, 0, 0, 0, 1, 3, 4};
        vecs[3] = '{9'd3,   16'h002D, -1, 0, 0, 3, 3, 0, 1, 1, 0, 3, 10};
        vecs[4] = '{9'd2,   16'h0003, -1, 0, 0, 2, 2, 0, 0, 1, 0, 3, 7};
        vecs[5] = '{9'd0,   16'h0000, -1, 0, 0, 0, 0, 0, 0, 1, 0, -1, 1};
        vecs[6] = '{9'd257, 16'h0000, -1, 0, 0, 0, 0, 0, 0, 0, 1, -1, 1};
        vecs[7] = '{9'd1,   16'h0002, -1, 0, 0, 1, 1, 0, 0, 0, 1, 3, 4};

        for (int c = 0; c < 4; c++) begin
            run        = 1'($urandom);
            path_len   = 9'($urandom);
            move_ready = 1'($urandom);
            tick();
            chk("reset_outs",
                int'({rd_en, rd_addr, move, move_valid, x, y, busy, done, err}),
                0);
        end
        run = 1'b0;
        rst = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 8; i++) mem[i] = vecs[v].moves[2*i +: 2];
            replay(vecs[v].len, vecs[v].s_idx, vecs[v].s_n, vecs[v].s_x);
            chk($sformatf("v%0d_acc", v), acc, vecs[v].e_acc);
            chk($sformatf("v%0d_reads", v), reads, vecs[v].e_reads);
            chk($sformatf("v%0d_x", v), int'(x), vecs[v].ex);
            chk($sformatf("v%0d_y", v), int'(y), vecs[v].ey);
            chk($sformatf("v%0d_done", v), int'(done), vecs[v].e_done);
            chk($sformatf("v%0d_err", v), int'(err), vecs[v].e_err);
            chk($sformatf("v%0d_first", v), first_v, vecs[v].e_first);
            chk($sformatf("v%0d_end", v), end_cyc, vecs[v].e_end);
            tick();
        end

        // Reset during SHOW of the third move.
        for (int i = 0; i < 8; i++) mem[i] = vecs[0].moves[2*i +: 2];
        path_len   = 9'd4;
        move_ready = 1'b1;
        run        = 1'b1;
        tick();
        run = 1'b0;
        repeat (8) tick();
        chk("mid_valid_pre", int'(move_valid), 1);
        chk("mid_x_pre", int'(x), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_valid_rst", int'(move_valid), 0);
        chk("mid_busy_rst", int'(busy), 0);
        chk("mid_xy_rst", int'({x, y}), 0);
        tick();
        rst = 1'b1;
        tick();
        replay(9'd4, -1, 0, 0);
        chk("mid_first", first_v, 3);
        chk("mid_end", end_cyc, 13);
        chk("mid_x", int'(x), 2);
        chk("mid_y", int'(y), 2);
        chk("mid_done", int'(done), 1);

        // Right-edge trap after 15 legal steps.
        for (int i = 0; i < 16; i++) mem[i] = 2'b01;
        replay(9'd16, -1, 0, 0);
        chk("edge_acc", acc, 16);
        chk("edge_x", int'(x), 15);
        chk("edge_y", int'(y), 0);
        chk("edge_err", int'(err), 1);
        chk("edge_reads", reads, 16);

        // Full-depth replay, alternating right/left.
        for (int i = 0; i < 256; i++) mem[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
        replay(9'd256, -1, 0, 0);
        chk("full_acc", acc, 256);
        chk("full_reads", reads, 256);
        chk("full_last_addr", last_addr, 255);
        chk("full_x", int'(x), 0);
        chk("full_y", int'(y), 0);
        chk("full_done", int'(done), 1);

        replay(9'd257, -1, 0, 0);
        chk("over_err", int'(err), 1);
        chk("over_end", end_cyc, 1);
        chk("over_reads", reads, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/path_replayer.md
# path_replayer

Reads the move sequence the maze solver leaves in its path stack and replays it to the rat drive logic as a stream of 2-bit moves over a valid/ready handshake. Entries are read bottom-to-top, so moves come out in the order they were pushed. A coordinate tracker applies each accepted move. The block flags any move that would leave the maze, then stops. It sits after the solver: once the solver reports done, the top level pulses `run` and hands over the stack pointer as `path_len`.

## Interface
- DEPTH, 256, path stack entries
- PTR_W, 8, stack address width (2^PTR_W = DEPTH)
- COORD_W, 4, x/y coordinate width; maze is 2^COORD_W × 2^COORD_W
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (low = reset)
- run  input  1  start-replay pulse; sampled only in IDLE, DONE, ERR
- path_len  input  PTR_W+1  number of valid stack entries, sampled on accepted `run`
- rd_en  output  1  stack read strobe
- rd_addr  output  PTR_W  stack read address
- rd_data  input  2  stack read data, valid the cycle after `rd_en`
- move  output  2  current move: 00 up (y−1), 01 right (x+1), 10 left (x−1), 11 down (y+1)
- move_valid  output  1  `move` is presented
- move_ready  input  1  consumer accepts `move`
- x, y  output  COORD_W each  current rat position
- busy  output  1  high in READ, LATCH, SHOW
- done  output  1  high while in DONE
- err  output  1  high while in ERR

## Operation
- States: IDLE, READ, LATCH, SHOW, DONE, ERR.
- Reset values: state IDLE; all outputs 0; idx = 0; x = y = 0.
- IDLE, DONE, ERR, on `run`:
  - If `path_len` > DEPTH: go to ERR.
  - Else if `path_len` = 0: go to DONE.
  - Else: latch `len` = `path_len`, clear idx, x, y to 0, go to READ.
- When `run` is 0, IDLE, DONE and ERR hold.
- READ: `rd_en` = 1, `rd_addr` = idx. Go to LATCH.
- LATCH: register `rd_data` into the move register. Go to SHOW.
- SHOW: `move_valid` = 1. `move` is held stable until accepted.
- Acceptance is `move_valid` & `move_ready`. On acceptance:
  - If the move is out of bounds (x = 0 & left, x = max & right, y = 0 & up, y = max & down): x and y stay unchanged, go to ERR.
  - Else update x/y by ±1. Then, if idx + 1 = `len`, go to DONE; otherwise idx ← idx + 1 and go to READ.
- When `move_ready` is 0, SHOW holds indefinitely.
- `run` is ignored while `busy`.
- `path_len` changes after acceptance have no effect.
- x/y arithmetic is COORD_W-bit unsigned. Wrap-around never occurs because out-of-bounds moves are trapped.
- idx is PTR_W+1 bits, so `len` = DEPTH is legal (last address DEPTH−1).
- `rst` low in any state returns to IDLE asynchronously, with all outputs at their reset values. A pending `move_valid` drops immediately.

## Timing
- `rd_en`, `rd_addr`, `move_valid`, `move`, `busy`, `done` and `err` are decoded from registered state and registered data only, with no combinational input→output path.
- `run` accepted at edge N:
  - READ during cycle N+1 (`rd_en` high).
  - LATCH during N+2.
  - `move_valid` first high during cycle N+3.
- Per-move cost: 3 cycles when `move_ready` is held high (READ, LATCH, SHOW). Each stall cycle adds 1.
- x/y update on the same edge as acceptance and are visible the next cycle.
- `done` or `err` rises in the cycle after the final acceptance (or the rejected move).
- A `run` accepted from DONE or ERR restarts with identical timing.

## Test plan
- Reset: hold `rst` = 0 with random inputs → all outputs 0, state IDLE. Release and pulse `run` with `path_len` = 0 → `done` = 1 at N+1, `rd_en` never asserted.
- Path {01,01,11,11} (addr 0..3), `move_ready` tied 1 → moves 01,01,11,11 in order, `move_valid` at N+3, N+6, N+9, N+12, final x = 2, y = 2, `done` at N+13.
- Backpressure: same path, `move_ready` low for 5 cycles on the 2nd move → `move` stays 01 throughout the stall, x = 1 unchanged until acceptance, final (2,2).
- Boundary: path {00} from (0,0) → `move_valid` with `move` = 00, on acceptance `err` = 1, x = y = 0, no further `rd_en`.
- Full depth: `path_len` = 256 alternating 01/10 → 256 accepted moves, last `rd_addr` = 255, final (0,0), `done`. `path_len` = 257 → `err` next cycle.
- Mid-op reset: assert `rst` = 0 during SHOW of move 3 → `move_valid` and `busy` drop asynchronously, x = y = 0. Then `run` → replay restarts from addr 0.
